// File: rtl/select_top_k_if.sv
// Bundle of the selection-stage signals: pass control, population bus,
// flow-controlled fitness stream and the gathered result.
interface select_top_k_if #(
    parameter int POP_SIZE  = 25,
    parameter int GENE_W    = 75,
    parameter int FIT_W     = 12,
    parameter int SEL_COUNT = 5
);
    localparam int IDX_W = $clog2(POP_SIZE);

    logic                          start;
    logic                          max_mode;
    logic [POP_SIZE*GENE_W-1:0]    pop;
    logic                          fit_valid;
    logic [FIT_W-1:0]              fit_data;
    logic                          fit_ready;
    logic [SEL_COUNT*GENE_W-1:0]   sel_pop;
    logic [SEL_COUNT*IDX_W-1:0]    sel_idx;
    logic                          busy;
    logic                          done;

    // Upstream side: drives the pass and the fitness stream
    modport master (
        output start, max_mode, pop, fit_valid, fit_data,
        input  fit_ready, sel_pop, sel_idx, busy, done
    );

    // Selection block side
    modport slave (
        input  start, max_mode, pop, fit_valid, fit_data,
        output fit_ready, sel_pop, sel_idx, busy, done
    );
endinterface

// File: rtl/select_top_k.sv
// Streaming top-K selection: keeps a sorted list of the K best fitness values
// seen so far (insertion, one per cycle), then gathers the chosen individuals.
module select_top_k #(
    parameter int POP_SIZE  = 25,
    parameter int GENE_W    = 75,
    parameter int FIT_W     = 12,
    parameter int SEL_COUNT = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    select_top_k_if.slave bus
);
    localparam int IDX_W = $clog2(POP_SIZE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(POP_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        GATHER,
        DONE
    } state_t;

    state_t                 state;
    logic                   mode_max;
    logic [IDX_W-1:0]       count;

    logic [SEL_COUNT-1:0]   ent_valid;
    logic [FIT_W-1:0]       ent_fit [SEL_COUNT];
    logic [IDX_W-1:0]       ent_idx [SEL_COUNT];

    logic [SEL_COUNT-1:0]   be;
    logic [SEL_COUNT-1:0]   nxt_valid;
    logic [FIT_W-1:0]       nxt_fit [SEL_COUNT];
    logic [IDX_W-1:0]       nxt_idx [SEL_COUNT];

    logic                   transfer;

    assign transfer = (state == COLLECT) && bus.fit_valid;

    // be[j] marks entries that stay ahead of the incoming value. Because the
    // list is sorted with valid entries first, be is a run of ones from slot 0,
    // so the insert position is the first slot whose be is clear. Equal fitness
    // counts as "ahead", which keeps earlier arrivals in front in both modes.
    for (genvar j = 0; j < SEL_COUNT; j++) begin : g_ent
        assign be[j] = ent_valid[j] &&
                       (mode_max ? (ent_fit[j] >= bus.fit_data)
                                 : (ent_fit[j] <= bus.fit_data));
        if (j == 0) begin : g_head
            assign nxt_valid[j] = be[j] ? ent_valid[j] : 1'b1;
            assign nxt_fit[j]   = be[j] ? ent_fit[j]   : bus.fit_data;
            assign nxt_idx[j]   = be[j] ? ent_idx[j]   : count;
        end else begin : g_tail
            assign nxt_valid[j] = be[j] ? ent_valid[j] : (be[j-1] ? 1'b1         : ent_valid[j-1]);
            assign nxt_fit[j]   = be[j] ? ent_fit[j]   : (be[j-1] ? bus.fit_data : ent_fit[j-1]);
            assign nxt_idx[j]   = be[j] ? ent_idx[j]   : (be[j-1] ? count        : ent_idx[j-1]);
        end
    end

    // Pass sequencer: collects the stream into the list, gathers, pulses done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            mode_max      <= 1'b0;
            count         <= '0;
            ent_valid     <= '0;
            for (int j = 0; j < SEL_COUNT; j++) begin
                ent_fit[j] <= '0;
                ent_idx[j] <= '0;
            end
            bus.fit_ready <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.sel_pop   <= '0;
            bus.sel_idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mode_max      <= bus.max_mode;
                        count         <= '0;
                        ent_valid     <= '0;
                        bus.fit_ready <= 1'b1;
                        bus.busy      <= 1'b1;
                        state         <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (transfer) begin
                        ent_valid <= nxt_valid;
                        for (int j = 0; j < SEL_COUNT; j++) begin
                            ent_fit[j] <= nxt_fit[j];
                            ent_idx[j] <= nxt_idx[j];
                        end
                        count <= count + IDX_W'(1);
                        if (count == LAST_IDX) begin
                            bus.fit_ready <= 1'b0;
                            state         <= GATHER;
                        end
                    end
                end
                GATHER: begin
                    for (int k = 0; k < SEL_COUNT; k++) begin
                        bus.sel_pop[k*GENE_W +: GENE_W] <= bus.pop[int'(ent_idx[k])*GENE_W +: GENE_W];
                        bus.sel_idx[k*IDX_W +: IDX_W]   <= ent_idx[k];
                    end
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_select_top_k.sv
// Scoreboard bench for select_top_k: stimulus pushes expected results,
// per-DUT monitors pop and compare whenever done is seen.
module tb_select_top_k;
    localparam int P1 = 25;
    localparam int G1 = 75;
    localparam int F1 = 12;
    localparam int K1 = 5;
    localparam int I1 = $clog2(P1);
    localparam int P2 = 4;
    localparam int G2 = 16;
    localparam int F2 = 12;
    localparam int K2 = 4;
    localparam int I2 = $clog2(P2);

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   got1 = 0;
    int   got2 = 0;

    typedef struct {
        logic [K1*I1-1:0] idx;
        logic [K1*G1-1:0] pop;
        int               done_cyc;
    } exp1_t;

    typedef struct {
        logic [K2*I2-1:0] idx;
        logic [K2*G2-1:0] pop;
        int               done_cyc;
    } exp2_t;

    exp1_t q1[$];
    exp2_t q2[$];

    logic [F1-1:0] fit_vec1 [P1];

    select_top_k_if #(.POP_SIZE(P1), .GENE_W(G1), .FIT_W(F1), .SEL_COUNT(K1)) bus1 ();
    select_top_k_if #(.POP_SIZE(P2), .GENE_W(G2), .FIT_W(F2), .SEL_COUNT(K2)) bus2 ();

    select_top_k #(.POP_SIZE(P1), .GENE_W(G1), .FIT_W(F1), .SEL_COUNT(K1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    select_top_k #(.POP_SIZE(P2), .GENE_W(G2), .FIT_W(F2), .SEL_COUNT(K2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    always #5 clk = ~clk;

    // Cycle counter used to time-stamp start and done
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [G1-1:0] gene1(input int i);
        return {11'(i), (64'(i) * 64'h9E37_79B9_7F4A_7C15) ^ 64'hA5A5_5A5A_0F0F_F0F0};
    endfunction

    function automatic logic [G2-1:0] gene2(input int i);
        return 16'hC0DE ^ (16'(i) * 16'h1111);
    endfunction

    function automatic exp1_t make_exp1(input int i0, input int i1, input int i2, input int i3, input int i4);
        exp1_t e;
        int    ids [K1];
        ids[0] = i0; ids[1] = i1; ids[2] = i2; ids[3] = i3; ids[4] = i4;
        e.idx = '0;
        e.pop = '0;
        e.done_cyc = 0;
        for (int k = 0; k < K1; k++) begin
            e.idx[k*I1 +: I1] = I1'(ids[k]);
            e.pop[k*G1 +: G1] = gene1(ids[k]);
        end
        return e;
    endfunction

    function automatic exp2_t make_exp2(input int i0, input int i1, input int i2, input int i3);
        exp2_t e;
        int    ids [K2];
        ids[0] = i0; ids[1] = i1; ids[2] = i2; ids[3] = i3;
        e.idx = '0;
        e.pop = '0;
        e.done_cyc = 0;
        for (int k = 0; k < K2; k++) begin
            e.idx[k*I2 +: I2] = I2'(ids[k]);
            e.pop[k*G2 +: G2] = gene2(ids[k]);
        end
        return e;
    endfunction

    // Reference: repeatedly pick the strictly best unused entry, scanning
    // upward so that equal values keep the lower index first
    function automatic exp1_t model1(input logic mode);
        bit used [P1];
        int ids [K1];
        int best;
        for (int i = 0; i < P1; i++) used[i] = 1'b0;
        for (int k = 0; k < K1; k++) begin
            best = -1;
            for (int i = 0; i < P1; i++) begin
                if (!used[i]) begin
                    if (best < 0) best = i;
                    else if (mode ? (fit_vec1[i] > fit_vec1[best]) : (fit_vec1[i] < fit_vec1[best])) best = i;
                end
            end
            used[best] = 1'b1;
            ids[k] = best;
        end
        return make_exp1(ids[0], ids[1], ids[2], ids[3], ids[4]);
    endfunction

    task automatic check_output(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor for the default-size instance
    always @(negedge clk) begin
        exp1_t e;
        if (bus1.done === 1'b1) begin
            got1++;
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL dut1_unexpected_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                e = q1.pop_front();
                check_output("dut1_sel_idx", 512'(bus1.sel_idx), 512'(e.idx));
                check_output("dut1_sel_pop", 512'(bus1.sel_pop), 512'(e.pop));
                check_output("dut1_done_cycle", 512'(cyc), 512'(e.done_cyc));
            end
        end
    end

    // Monitor for the small instance
    always @(negedge clk) begin
        exp2_t e;
        if (bus2.done === 1'b1) begin
            got2++;
            if (q2.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL dut2_unexpected_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                e = q2.pop_front();
                check_output("dut2_sel_idx", 512'(bus2.sel_idx), 512'(e.idx));
                check_output("dut2_sel_pop", 512'(bus2.sel_pop), 512'(e.pop));
                check_output("dut2_done_cycle", 512'(cyc), 512'(e.done_cyc));
            end
        end
    end

    // One pass on dut1; abort_after >= 0 stops after that many transfers
    task automatic apply_stimulus(input logic mode, input bit gaps, input int abort_after,
                                  input exp1_t e, input int delay);
        exp1_t ee;
        @(negedge clk);
        bus1.start     = 1'b1;
        bus1.max_mode  = mode;
        bus1.fit_valid = 1'b1;
        bus1.fit_data  = '0;
        if (abort_after < 0) begin
            ee = e;
            ee.done_cyc = cyc + delay;
            q1.push_back(ee);
        end
        @(negedge clk);
        bus1.start    = 1'b0;
        bus1.max_mode = ~mode;
        for (int i = 0; i < P1; i++) begin
            if (i == abort_after) return;
            if (gaps) begin
                bus1.fit_valid = 1'b0;
                bus1.fit_data  = '0;
                check_output("fit_ready_gap", 512'(bus1.fit_ready), 512'(1));
                @(negedge clk);
            end
            bus1.fit_valid = 1'b1;
            bus1.fit_data  = fit_vec1[i];
            check_output("fit_ready_collect", 512'(bus1.fit_ready), 512'(1));
            @(negedge clk);
        end
        bus1.fit_valid = 1'b1;
        bus1.fit_data  = '0;
        check_output("busy_gather", 512'(bus1.busy), 512'(1));
        check_output("fit_ready_gather", 512'(bus1.fit_ready), 512'(0));
        @(negedge clk);
        bus1.fit_valid = 1'b0;
    endtask

    task automatic wait_result1(input int target, input string name);
        int n;
        n = 0;
        while (got1 < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (got1 < target) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_timeout: got %0d results expected %0d", name, got1, target);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_sel_pop"}, 512'(bus1.sel_pop), 512'(0));
        check_output({tag, "_sel_idx"}, 512'(bus1.sel_idx), 512'(0));
        check_output({tag, "_done"}, 512'(bus1.done), 512'(0));
        check_output({tag, "_busy"}, 512'(bus1.busy), 512'(0));
        check_output({tag, "_fit_ready"}, 512'(bus1.fit_ready), 512'(0));
    endtask

    // Main directed sequence
    initial begin
        logic [F2-1:0] fit2 [P2];
        exp2_t         e2;

        bus1.start = 1'b0; bus1.max_mode = 1'b0; bus1.fit_valid = 1'b0; bus1.fit_data = '0;
        bus2.start = 1'b0; bus2.max_mode = 1'b0; bus2.fit_valid = 1'b0; bus2.fit_data = '0;
        for (int i = 0; i < P1; i++) bus1.pop[i*G1 +: G1] = gene1(i);
        for (int i = 0; i < P2; i++) bus2.pop[i*G2 +: G2] = gene2(i);

        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        check_output("reset_dut2_done", 512'(bus2.done), 512'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Descending fitness, min mode: the last five indices win
        for (int i = 0; i < P1; i++) fit_vec1[i] = F1'(100 - i);
        apply_stimulus(1'b0, 1'b0, -1, make_exp1(24, 23, 22, 21, 20), 27);
        wait_result1(1, "t1");

        // All equal, both modes: arrival order is kept
        for (int i = 0; i < P1; i++) fit_vec1[i] = F1'(7);
        apply_stimulus(1'b0, 1'b0, -1, make_exp1(0, 1, 2, 3, 4), 27);
        wait_result1(2, "t2_min");
        apply_stimulus(1'b1, 1'b0, -1, make_exp1(0, 1, 2, 3, 4), 27);
        wait_result1(3, "t2_max");

        // Scrambled values, max mode: 48,46,44,42,40 at 4,8,12,16,20
        for (int i = 0; i < P1; i++) fit_vec1[i] = F1'((i * 37) % 50);
        apply_stimulus(1'b1, 1'b0, -1, model1(1'b1), 27);
        wait_result1(4, "t3");
        apply_stimulus(1'b0, 1'b0, -1, model1(1'b0), 27);
        wait_result1(5, "t3_min");

        // Valid toggling: 25 idle beats stretch the pass
        for (int i = 0; i < P1; i++) fit_vec1[i] = F1'(100 - i);
        apply_stimulus(1'b0, 1'b1, -1, make_exp1(24, 23, 22, 21, 20), 52);
        wait_result1(6, "t4");

        // Abort by reset after 10 transfers, then a clean pass
        apply_stimulus(1'b0, 1'b0, 10, make_exp1(0, 0, 0, 0, 0), 0);
        rst_n = 1'b0;
        #1 check_reset_outputs("abort");
        bus1.fit_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check_output("abort_no_done", 512'(got1), 512'(6));
        apply_stimulus(1'b0, 1'b0, -1, make_exp1(24, 23, 22, 21, 20), 27);
        wait_result1(7, "t5");

        // K == POP_SIZE instance, start pulsed in COLLECT and in DONE
        fit2[0] = F2'(3); fit2[1] = F2'(1); fit2[2] = F2'(2); fit2[3] = F2'(0);
        @(negedge clk);
        bus2.start     = 1'b1;
        bus2.max_mode  = 1'b0;
        bus2.fit_valid = 1'b1;
        bus2.fit_data  = '0;
        e2 = make_exp2(3, 1, 2, 0);
        e2.done_cyc = cyc + P2 + 2;
        q2.push_back(e2);
        for (int i = 0; i < P2; i++) begin
            @(negedge clk);
            bus2.start     = (i == 1);
            bus2.max_mode  = (i == 1);
            bus2.fit_valid = 1'b1;
            bus2.fit_data  = fit2[i];
            check_output("dut2_fit_ready", 512'(bus2.fit_ready), 512'(1));
        end
        @(negedge clk);
        bus2.start     = 1'b0;
        bus2.fit_valid = 1'b0;
        check_output("dut2_busy_gather", 512'(bus2.busy), 512'(1));
        @(negedge clk);
        check_output("dut2_done_pulse", 512'(bus2.done), 512'(1));
        bus2.start    = 1'b1;
        bus2.max_mode = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        check_output("dut2_busy_after_done", 512'(bus2.busy), 512'(0));
        check_output("dut2_ready_after_done", 512'(bus2.fit_ready), 512'(0));
        check_output("dut2_done_cleared", 512'(bus2.done), 512'(0));
        repeat (10) @(negedge clk);
        check_output("dut2_busy_idle", 512'(bus2.busy), 512'(0));
        check_output("dut2_done_count", 512'(got2), 512'(1));
        check_output("dut1_queue_empty", 512'(q1.size()), 512'(0));

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
